// File: rtl/qed_imem_wr_sched.sv
// Arbitrates the single I-mem write port between the host loader and a buffered
// QED instruction stream that fills a fixed, consecutive word region.
module qed_imem_wr_sched #(
  parameter logic [31:0] QED_BASE   = 32'h0000_0100,
  parameter int          QED_WORDS  = 64,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        qed_vld_i,
  input  logic [31:0] qed_instr_i,
  input  logic        ld_vld_i,
  input  logic [31:0] ld_addr_i,
  input  logic [31:0] ld_data_i,
  output logic        ld_rdy_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic        mem_w_en_o,
  output logic        done_o,
  output logic        ovf_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(QED_WORDS + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CAPTURE = 2'd1, S_DONE = 2'd2} state_e;

  state_e        state_q, state_d;
  logic [31:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] acc_q, acc_d;
  logic          ovf_q, ovf_d;
  logic          prio_qed_q, prio_qed_d;
  logic [AW:0]   fwp_q, fwp_d, frp_q, frp_d;
  logic [31:0]   fifo_q [FIFO_DEPTH];
  logic          mem_w_en_q, mem_w_en_d;
  logic [31:0]   mem_addr_q, mem_addr_d, mem_data_q, mem_data_d;

  logic capt, fifo_empty, fifo_full, qed_cand;
  logic grant_qed, grant_ld, push_try, push, drop;

  // acc_q tracks count + FIFO occupancy: words accepted in this capture window
  assign capt       = (state_q == S_CAPTURE) && en_i;
  assign fifo_empty = (fwp_q == frp_q);
  assign fifo_full  = (fwp_q[AW] != frp_q[AW]) && (fwp_q[AW-1:0] == frp_q[AW-1:0]);
  assign qed_cand   = capt && !fifo_empty;
  assign grant_qed  = qed_cand && (!ld_vld_i || prio_qed_q);
  assign grant_ld   = ld_vld_i && !grant_qed;
  assign push_try   = capt && qed_vld_i && (acc_q < CW'(QED_WORDS));
  assign push       = push_try && (!fifo_full || grant_qed);
  assign drop       = push_try && fifo_full && !grant_qed;

  assign ld_rdy_o   = grant_ld;
  assign mem_w_en_o = mem_w_en_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_data_o = mem_data_q;
  assign done_o     = (state_q == S_DONE);
  assign ovf_o      = ovf_q;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    prio_qed_d = prio_qed_q;
    fwp_d      = fwp_q;
    frp_d      = frp_q;
    mem_w_en_d = grant_qed || grant_ld;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;

    if (push) begin
      fwp_d = fwp_q + (AW+1)'(1);
      acc_d = acc_q + CW'(1);
    end
    if (drop) ovf_d = 1'b1;
    if (qed_cand && ld_vld_i) prio_qed_d = !prio_qed_q;

    if (grant_qed) begin
      frp_d      = frp_q + (AW+1)'(1);
      wr_ptr_d   = wr_ptr_q + 32'd4;
      cnt_d      = cnt_q + CW'(1);
      mem_addr_d = wr_ptr_q;
      mem_data_d = fifo_q[frp_q[AW-1:0]];
    end else if (grant_ld) begin
      mem_addr_d = ld_addr_i;
      mem_data_d = ld_data_i;
    end

    case (state_q)
      S_IDLE: begin
        if (en_i) begin
          state_d  = S_CAPTURE;
          wr_ptr_d = QED_BASE;
          cnt_d    = '0;
          acc_d    = '0;
          ovf_d    = 1'b0;
          fwp_d    = '0;
          frp_d    = '0;
        end
      end
      S_CAPTURE: begin
        if (!en_i) begin
          state_d = S_IDLE;
          fwp_d   = '0;
          frp_d   = '0;
        end else if (grant_qed && (cnt_q == CW'(QED_WORDS - 1))) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!en_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= QED_BASE;
      cnt_q      <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      prio_qed_q <= 1'b1;
      fwp_q      <= '0;
      frp_q      <= '0;
      mem_w_en_q <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      prio_qed_q <= prio_qed_d;
      fwp_q      <= fwp_d;
      frp_q      <= frp_d;
      mem_w_en_q <= mem_w_en_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

  // Buffer storage carries no reset; occupancy is governed by the pointers
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[fwp_q[AW-1:0]] <= qed_instr_i;
  end
endmodule

// File: tb/tb_qed_imem_wr_sched.sv
// Randomized bench for qed_imem_wr_sched against a queue-based behavioural model.
module tb_qed_imem_wr_sched;
  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam int          WORDS = 16;
  localparam int          DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, qvld, lvld;
  logic [31:0] qinstr, laddr, ldata;
  logic        ld_rdy, wen, done, ovf;
  logic [31:0] maddr, mdata;

  qed_imem_wr_sched #(.QED_BASE(BASE), .QED_WORDS(WORDS), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .qed_vld_i(qvld), .qed_instr_i(qinstr),
    .ld_vld_i(lvld), .ld_addr_i(laddr), .ld_data_i(ldata), .ld_rdy_o(ld_rdy),
    .mem_addr_o(maddr), .mem_data_o(mdata), .mem_w_en_o(wen), .done_o(done), .ovf_o(ovf)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Behavioural model: mode 0 idle, 1 capture, 2 done; FIFO is a plain queue
  int          m_mode = 0;
  logic [31:0] mq[$];
  logic [31:0] m_ptr = BASE;
  int          m_cnt = 0;
  bit          m_ovf = 0;
  bit          m_last_ld = 1;
  logic        e_rdy, e_wen, e_done, e_ovf, a_rdy;
  logic [31:0] e_addr, e_data;

  task automatic model_step();
    bit capt, qc, gq, gl, try_push, do_push;
    int occ;
    capt  = (m_mode == 1) && en;
    qc    = capt && (mq.size() > 0);
    gq    = qc && (!lvld || m_last_ld);
    gl    = lvld && !gq;
    e_rdy = gl;
    if (!rst_n) begin
      m_mode = 0; mq.delete(); m_ptr = BASE; m_cnt = 0; m_ovf = 0; m_last_ld = 1;
      e_wen = 0; e_addr = '0; e_data = '0; e_done = 0; e_ovf = 0;
      return;
    end
    occ      = mq.size();
    try_push = capt && qvld && (m_cnt + occ < WORDS);
    do_push  = try_push && (occ < DEPTH || gq);
    if (try_push && !do_push) m_ovf = 1;
    if (qc && lvld) m_last_ld = gl;
    e_wen = gq || gl;
    if (gq) begin
      e_addr = m_ptr; e_data = mq.pop_front(); m_ptr += 4; m_cnt++;
    end else if (gl) begin
      e_addr = laddr; e_data = ldata;
    end
    if (do_push) mq.push_back(qinstr);
    case (m_mode)
      0: if (en) begin m_mode = 1; m_ptr = BASE; m_cnt = 0; m_ovf = 0; mq.delete(); end
      1: if (!en) begin m_mode = 0; mq.delete(); end else if (m_cnt == WORDS) m_mode = 2;
      default: if (!en) m_mode = 0;
    endcase
    e_done = (m_mode == 2);
    e_ovf  = m_ovf;
  endtask

  // Runs the model on the inputs held for this cycle, then advances the DUT one edge
  task automatic tick();
    @(negedge clk);
    model_step();
    a_rdy = ld_rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; en = 0; qvld = 0; lvld = 0; qinstr = '0; laddr = '0; ldata = '0;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_chk++;
      if ({a_rdy, wen, maddr, mdata, done, ovf} !== {e_rdy, e_wen, e_addr, e_data, e_done, e_ovf})
        $display("FAIL reset_init got rdy=%b wen=%b a=%h d=%h done=%b ovf=%b exp %b %b %h %h %b %b",
                 a_rdy, wen, maddr, mdata, done, ovf, e_rdy, e_wen, e_addr, e_data, e_done, e_ovf);
      else n_pass++;
    end
    rst_n = 1; en = 1; lvld = 1; laddr = 32'h40; ldata = 32'hDEAD;
    for (int k = 0; k < 7; k++) begin
      qvld = (k > 0); qinstr = $urandom;
      tick();
      n_chk++;
      if ({a_rdy, wen, maddr, mdata, done, ovf} !== {e_rdy, e_wen, e_addr, e_data, e_done, e_ovf})
        $display("FAIL reset_fill got rdy=%b wen=%b a=%h d=%h done=%b ovf=%b exp %b %b %h %h %b %b",
                 a_rdy, wen, maddr, mdata, done, ovf, e_rdy, e_wen, e_addr, e_data, e_done, e_ovf);
      else n_pass++;
    end
    rst_n = 0; qvld = 0; lvld = 0;
    tick();
    n_chk++;
    if ({wen, done, ovf, maddr} !== {1'b0, 1'b0, 1'b0, 32'h0})
      $display("FAIL reset_mid got wen=%b done=%b ovf=%b a=%h exp 0 0 0 0", wen, done, ovf, maddr);
    else n_pass++;
    rst_n = 1; en = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_chk++;
      if ({a_rdy, wen, maddr, mdata, done, ovf} !== {e_rdy, e_wen, e_addr, e_data, e_done, e_ovf})
        $display("FAIL reset_stale got rdy=%b wen=%b a=%h d=%h done=%b ovf=%b exp %b %b %h %h %b %b",
                 a_rdy, wen, maddr, mdata, done, ovf, e_rdy, e_wen, e_addr, e_data, e_done, e_ovf);
      else n_pass++;
    end
  endtask

  task automatic test_basic();
    logic [31:0] instrs [3];
    for (int i = 0; i < 3; i++) instrs[i] = $urandom;
    en = 1; qvld = 0; lvld = 0;
    for (int k = -1; k < 5; k++) begin
      qvld = (k >= 0 && k < 3);
      if (qvld) qinstr = instrs[k];
      tick();
      n_chk++;
      if ({a_rdy, wen, maddr, mdata, done, ovf} !== {e_rdy, e_wen, e_addr, e_data, e_done, e_ovf})
        $display("FAIL basic got rdy=%b wen=%b a=%h d=%h done=%b ovf=%b exp %b %b %h %h %b %b",
                 a_rdy, wen, maddr, mdata, done, ovf, e_rdy, e_wen, e_addr, e_data, e_done, e_ovf);
      else n_pass++;
      if (k >= 1 && k <= 3) begin
        n_chk++;
        if ({wen, maddr, mdata} !== {1'b1, BASE + 32'(4 * (k - 1)), instrs[k-1]})
          $display("FAIL basic_seq got wen=%b a=%h d=%h exp 1 %h %h",
                   wen, maddr, mdata, BASE + 32'(4 * (k - 1)), instrs[k-1]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_arbitration();
    lvld = 1; laddr = 32'h40; ldata = 32'hDEAD;
    for (int k = 0; k < 10; k++) begin
      qvld = (k < 5); qinstr = $urandom;
      tick();
      n_chk++;
      if ({a_rdy, wen, maddr, mdata, done, ovf} !== {e_rdy, e_wen, e_addr, e_data, e_done, e_ovf})
        $display("FAIL arb got rdy=%b wen=%b a=%h d=%h done=%b ovf=%b exp %b %b %h %h %b %b",
                 a_rdy, wen, maddr, mdata, done, ovf, e_rdy, e_wen, e_addr, e_data, e_done, e_ovf);
      else n_pass++;
    end
  endtask

  task automatic test_fill_done();
    for (int k = 0; k < 36; k++) begin
      qvld = (k < 24); qinstr = $urandom;
      lvld = (k < 24) && ($urandom_range(0, 3) == 0); laddr = $urandom & ~32'h3; ldata = $urandom;
      tick();
      n_chk++;
      if ({a_rdy, wen, maddr, mdata, done, ovf} !== {e_rdy, e_wen, e_addr, e_data, e_done, e_ovf})
        $display("FAIL fill got rdy=%b wen=%b a=%h d=%h done=%b ovf=%b exp %b %b %h %h %b %b",
                 a_rdy, wen, maddr, mdata, done, ovf, e_rdy, e_wen, e_addr, e_data, e_done, e_ovf);
      else n_pass++;
    end
    n_chk++;
    if (done !== 1'b1) $display("FAIL fill_done got done=%b exp 1", done);
    else n_pass++;
    en = 0; qvld = 0; lvld = 0;
    tick();
    n_chk++;
    if ({done, wen} !== 2'b00) $display("FAIL done_exit got done=%b wen=%b exp 0 0", done, wen);
    else n_pass++;
  endtask

  task automatic test_overflow();
    en = 1; lvld = 1; laddr = 32'h40;
    for (int k = -1; k < 20; k++) begin
      qvld = (k >= 0 && k < 12); qinstr = $urandom;
      if (k >= 12) lvld = 0;
      ldata = $urandom;
      tick();
      n_chk++;
      if ({a_rdy, wen, maddr, mdata, done, ovf} !== {e_rdy, e_wen, e_addr, e_data, e_done, e_ovf})
        $display("FAIL ovf got rdy=%b wen=%b a=%h d=%h done=%b ovf=%b exp %b %b %h %h %b %b",
                 a_rdy, wen, maddr, mdata, done, ovf, e_rdy, e_wen, e_addr, e_data, e_done, e_ovf);
      else n_pass++;
    end
    n_chk++;
    if (ovf !== 1'b1) $display("FAIL ovf_sticky got ovf=%b exp 1", ovf);
    else n_pass++;
  endtask

  task automatic test_disable();
    lvld = 1; laddr = 32'h80;
    for (int k = 0; k < 4; k++) begin
      qvld = 1; qinstr = $urandom; ldata = $urandom;
      tick();
    end
    en = 0; qvld = 0; lvld = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_chk++;
      if ({a_rdy, wen, maddr, mdata, done, ovf} !== {e_rdy, e_wen, e_addr, e_data, e_done, e_ovf})
        $display("FAIL disable got rdy=%b wen=%b a=%h d=%h done=%b ovf=%b exp %b %b %h %h %b %b",
                 a_rdy, wen, maddr, mdata, done, ovf, e_rdy, e_wen, e_addr, e_data, e_done, e_ovf);
      else n_pass++;
    end
    en = 1;
    for (int k = 0; k < 3; k++) begin
      qvld = (k == 1); qinstr = 32'hC0DE_0000 + 32'(k);
      tick();
      n_chk++;
      if ({a_rdy, wen, maddr, mdata, done, ovf} !== {e_rdy, e_wen, e_addr, e_data, e_done, e_ovf})
        $display("FAIL reenable got rdy=%b wen=%b a=%h d=%h done=%b ovf=%b exp %b %b %h %h %b %b",
                 a_rdy, wen, maddr, mdata, done, ovf, e_rdy, e_wen, e_addr, e_data, e_done, e_ovf);
      else n_pass++;
    end
    n_chk++;
    if ({wen, maddr, mdata, ovf} !== {1'b1, BASE, 32'hC0DE_0001, 1'b0})
      $display("FAIL restart got wen=%b a=%h d=%h ovf=%b exp 1 %h c0de0001 0", wen, maddr, mdata, ovf, BASE);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rst_n  = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 19) == 0) en = ~en;
      qvld   = $urandom_range(0, 1); qinstr = $urandom;
      lvld   = ($urandom_range(0, 2) == 0); laddr = $urandom & ~32'h3; ldata = $urandom;
      tick();
      n_chk++;
      if ({a_rdy, wen, maddr, mdata, done, ovf} !== {e_rdy, e_wen, e_addr, e_data, e_done, e_ovf})
        $display("FAIL random got rdy=%b wen=%b a=%h d=%h done=%b ovf=%b exp %b %b %h %h %b %b",
                 a_rdy, wen, maddr, mdata, done, ovf, e_rdy, e_wen, e_addr, e_data, e_done, e_ovf);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_arbitration();
    test_fill_done();
    test_overflow();
    test_disable();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
